// File: rtl/pll_phase_ctrl.sv
// PLL dynamic phase-shift sequencer with lock qualification and qualified system reset.
// Optional lock-loss counter output enabled by defining PLL_PHASE_LOSSCNT_EN.
module pll_phase_ctrl #(
    parameter int SETUP_CYC   = 4,
    parameter int PULSE_CYC   = 4,
    parameter int LOCK_FILTER = 16
) (
    input  logic       clkin,
    input  logic       resetn,
    input  logic       locked,
    input  logic       req_valid,
    input  logic [1:0] req_sel,
    input  logic       req_dir,
    input  logic [3:0] req_steps,
    output logic       req_ready,
    output logic       busy,
    output logic       done,
    output logic       abort,
    output logic       sys_resetn,
    output logic [1:0] phasesel,
    output logic       phasedir,
    output logic       phasestep
`ifdef PLL_PHASE_LOSSCNT_EN
    ,
    output logic [7:0] loss_cnt
`endif
);

    localparam int LOCK_W  = $clog2(LOCK_FILTER + 1);
    localparam int CYC_MAX = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        GAP,
        DONE
    } state_t;

    state_t            state;
    state_t            nextState;
    logic              lockMeta;
    logic              lockS;
    logic [LOCK_W-1:0] lockCnt;
    logic              lockOk;
    logic [CYC_W-1:0]  cycCnt;
    logic [3:0]        stepsLeft;
    logic              accept;
    logic              abortNext;
    logic              stepLowNext;
    logic              setupLast;
    logic              pulseLast;
    logic              seqActive;

    // Two-flop synchroniser for the asynchronous PLL lock.
    // NOTE: sequential state always uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            lockMeta <= 1'b0;
            lockS    <= 1'b0;
        end else begin
            lockMeta <= locked;
            lockS    <= lockMeta;
        end
    end

    // Consecutive-high filter; a single low sample restarts qualification.
    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            lockCnt <= '0;
        end else if (!lockS) begin
            lockCnt <= '0;
        end else if (lockCnt != LOCK_W'(LOCK_FILTER)) begin
            lockCnt <= lockCnt + 1'b1;
        end
    end

    assign lockOk = lockS && (lockCnt == LOCK_W'(LOCK_FILTER));

    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            sys_resetn <= 1'b0;
        end else begin
            sys_resetn <= lockOk;
        end
    end

    assign setupLast = (cycCnt == CYC_W'(SETUP_CYC - 1));
    assign pulseLast = (cycCnt == CYC_W'(PULSE_CYC - 1));
    assign seqActive = (state == SETUP) || (state == PULSE) || (state == GAP);

    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // NOTE: every output of this block gets a default first so no path leaves a latch behind.
    always_comb begin
        nextState   = state;
        accept      = 1'b0;
        abortNext   = 1'b0;
        req_ready   = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        stepLowNext = 1'b0;
        case (state)
            IDLE: begin
                busy      = 1'b0;
                req_ready = lockOk;
                if (req_valid && lockOk) begin
                    accept    = 1'b1;
                    nextState = (req_steps != 4'd0) ? SETUP : DONE;
                end
            end
            SETUP: begin
                if (!lockOk) begin
                    nextState = IDLE;
                end else if (setupLast) begin
                    nextState = PULSE;
                end
            end
            PULSE: begin
                stepLowNext = lockOk;
                if (!lockOk) begin
                    nextState = IDLE;
                end else if (pulseLast) begin
                    nextState = GAP;
                end
            end
            GAP: begin
                if (!lockOk) begin
                    nextState = IDLE;
                end else if (pulseLast) begin
                    nextState = (stepsLeft != 4'd0) ? PULSE : DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
        abortNext = seqActive && !lockOk;
    end

    // Cycle counter restarts on every state change.
    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            cycCnt <= '0;
        end else if ((state != nextState) || (state == IDLE)) begin
            cycCnt <= '0;
        end else begin
            cycCnt <= cycCnt + 1'b1;
        end
    end

    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            phasesel  <= 2'd0;
            phasedir  <= 1'b1;
            stepsLeft <= 4'd0;
        end else if (accept) begin
            phasesel  <= req_sel;
            phasedir  <= req_dir;
            stepsLeft <= req_steps;
        end else if ((state == PULSE) && (nextState == GAP)) begin
            stepsLeft <= stepsLeft - 4'd1;
        end
    end

    // Registered strobe: the low pulse trails PULSE by one cycle, giving SETUP_CYC+1 of setup.
    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            phasestep <= 1'b1;
            abort     <= 1'b0;
        end else begin
            phasestep <= !stepLowNext;
            abort     <= abortNext;
        end
    end

`ifdef PLL_PHASE_LOSSCNT_EN
    logic lockOkQ;

    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            lockOkQ  <= 1'b0;
            loss_cnt <= 8'd0;
        end else begin
            lockOkQ <= lockOk;
            if (lockOkQ && !lockOk && (loss_cnt != 8'hFF)) begin
                loss_cnt <= loss_cnt + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Directed self-checking bench for pll_phase_ctrl at default parameters.
// Covers lock qualification, stepping, zero-step, busy hold-off, abort, async reset, loss counter.
module tb_pll_phase_ctrl;

    logic       clkin;
    logic       resetn;
    logic       locked;
    logic       req_valid;
    logic [1:0] req_sel;
    logic       req_dir;
    logic [3:0] req_steps;
    logic       req_ready;
    logic       busy;
    logic       done;
    logic       abort;
    logic       sys_resetn;
    logic [1:0] phasesel;
    logic       phasedir;
    logic       phasestep;
`ifdef PLL_PHASE_LOSSCNT_EN
    logic [7:0] loss_cnt;
`endif

    int nChecks = 0;
    int nFails  = 0;

    pll_phase_ctrl dut (
        .clkin      (clkin),
        .resetn     (resetn),
        .locked     (locked),
        .req_valid  (req_valid),
        .req_sel    (req_sel),
        .req_dir    (req_dir),
        .req_steps  (req_steps),
        .req_ready  (req_ready),
        .busy       (busy),
        .done       (done),
        .abort      (abort),
        .sys_resetn (sys_resetn),
        .phasesel   (phasesel),
        .phasedir   (phasedir),
        .phasestep  (phasestep)
`ifdef PLL_PHASE_LOSSCNT_EN
        ,
        .loss_cnt   (loss_cnt)
`endif
    );

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge and sample 1 time unit after it.
    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    // Ticks until req_ready; returns tick count, or -1 if the budget expires.
    task automatic waitReady(input int budget, output int k);
        k = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (req_ready) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic request(input logic [1:0] sel, input logic dir, input logic [3:0] steps);
        req_sel   = sel;
        req_dir   = dir;
        req_steps = steps;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        int readyAt, sysAt, k;
        int patErr, busyCnt, doneCnt, doneAt, selErr, lowCnt, abortCnt;
        logic psHist[0:40];
        logic abHist[0:40];
        logic bzHist[0:40];
        logic rdHist[0:40];
        logic srHist[0:40];

        resetn    = 1'b0;
        locked    = 1'b0;
        req_valid = 1'b0;
        req_sel   = 2'd0;
        req_dir   = 1'b1;
        req_steps = 4'd0;
        tick();
        tick();
        check("rst phasesel", 32'(phasesel), 0);
        check("rst phasedir", 32'(phasedir), 1);
        check("rst phasestep", 32'(phasestep), 1);
        check("rst req_ready", 32'(req_ready), 0);
        check("rst busy", 32'(busy), 0);
        check("rst done", 32'(done), 0);
        check("rst abort", 32'(abort), 0);
        check("rst sys_resetn", 32'(sys_resetn), 0);

        // Lock qualification: ready after edge 18, sys_resetn after edge 19.
        locked = 1'b1;
        tick();
        tick();
        check("rst held sys_resetn", 32'(sys_resetn), 0);
        resetn  = 1'b1;
        readyAt = -1;
        sysAt   = -1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (req_ready && readyAt < 0) readyAt = i;
            if (sys_resetn && sysAt < 0) sysAt = i;
        end
        check("lock ready edge", 32'(readyAt), 18);
        check("lock sys_resetn edge", 32'(sysAt), 19);

        // Three steps on CLKOS2, lead: lows at samples 5-8, 13-16, 21-24; DONE at 28.
        request(2'd2, 1'b0, 4'd3);
        patErr = 0; busyCnt = 0; doneCnt = 0; doneAt = -1; selErr = 0; abortCnt = 0;
        for (int j = 0; j < 40; j++) begin
            logic expLow;
            expLow = (j >= 5 && j <= 8) || (j >= 13 && j <= 16) || (j >= 21 && j <= 24);
            if (phasestep !== !expLow) patErr++;
            if (busy) busyCnt++;
            if (done) begin doneCnt++; doneAt = j; end
            if (abort) abortCnt++;
            if (busy && (phasesel !== 2'd2 || phasedir !== 1'b0)) selErr++;
            tick();
        end
        check("seq3 step pattern errors", 32'(patErr), 0);
        check("seq3 busy cycles", 32'(busyCnt), 29);
        check("seq3 done count", 32'(doneCnt), 1);
        check("seq3 done sample", 32'(doneAt), 28);
        check("seq3 sel/dir errors", 32'(selErr), 0);
        check("seq3 abort count", 32'(abortCnt), 0);
        check("seq3 idle phasesel", 32'(phasesel), 2);
        check("seq3 idle phasedir", 32'(phasedir), 0);
        check("seq3 idle ready", 32'(req_ready), 1);

        // Zero steps: done right after accept, no strobe.
        request(2'd1, 1'b1, 4'd0);
        lowCnt = 0; busyCnt = 0; doneAt = -1;
        for (int j = 0; j < 10; j++) begin
            if (!phasestep) lowCnt++;
            if (busy) busyCnt++;
            if (done && doneAt < 0) doneAt = j;
            tick();
        end
        check("seq0 low count", 32'(lowCnt), 0);
        check("seq0 busy cycles", 32'(busyCnt), 1);
        check("seq0 done sample", 32'(doneAt), 0);
        check("seq0 phasesel", 32'(phasesel), 1);
        check("seq0 phasedir", 32'(phasedir), 1);

        // req_valid held: one-step sequence busy 0-12, idle at 13, re-accept at 14.
        req_sel   = 2'd3;
        req_dir   = 1'b1;
        req_steps = 4'd1;
        req_valid = 1'b1;
        tick();
        for (int j = 0; j <= 14; j++) begin
            bzHist[j] = busy;
            rdHist[j] = req_ready;
            if (j < 14) tick();
        end
        req_valid = 1'b0;
        check("hold busy s12", 32'(bzHist[12]), 1);
        check("hold busy s13", 32'(bzHist[13]), 0);
        check("hold ready s13", 32'(rdHist[13]), 1);
        check("hold busy s14", 32'(bzHist[14]), 1);
        waitReady(40, k);
        check("hold second seq ends", 32'(k > 0), 1);

        // Abort: lock lost during second PULSE of a five-step request.
        request(2'd0, 1'b1, 4'd5);
        doneCnt = 0; abortCnt = 0;
        for (int j = 0; j <= 20; j++) begin
            psHist[j] = phasestep;
            abHist[j] = abort;
            bzHist[j] = busy;
            rdHist[j] = req_ready;
            srHist[j] = sys_resetn;
            if (done) doneCnt++;
            if (abort) abortCnt++;
            if (j == 12) locked = 1'b0;
            tick();
        end
        check("abort phasestep s14", 32'(psHist[14]), 0);
        check("abort phasestep s15", 32'(psHist[15]), 1);
        check("abort pulse s15", 32'(abHist[15]), 1);
        check("abort busy s14", 32'(bzHist[14]), 1);
        check("abort busy s15", 32'(bzHist[15]), 0);
        check("abort ready s15", 32'(rdHist[15]), 0);
        check("abort sys_resetn s15", 32'(srHist[15]), 0);
        check("abort count", 32'(abortCnt), 1);
        check("abort done count", 32'(doneCnt), 0);

        // Relock with requests presented while not ready: all ignored.
        locked    = 1'b1;
        req_valid = 1'b1;
        req_steps = 4'd2;
        busyCnt   = 0;
        readyAt   = -1;
        for (int i = 1; i <= 24; i++) begin
            tick();
            if (i == 10) req_valid = 1'b0;
            if (busy) busyCnt++;
            if (req_ready && readyAt < 0) readyAt = i;
        end
        check("relock ready edge", 32'(readyAt), 18);
        check("relock ignored req busy", 32'(busyCnt), 0);

        // Asynchronous reset in the middle of a low pulse.
        request(2'd3, 1'b0, 4'd3);
        for (int j = 0; j < 6; j++) tick();
        check("midrst pre phasestep", 32'(phasestep), 0);
        #2;
        resetn = 1'b0;
        #1;
        check("midrst phasestep", 32'(phasestep), 1);
        check("midrst phasesel", 32'(phasesel), 0);
        check("midrst phasedir", 32'(phasedir), 1);
        check("midrst busy", 32'(busy), 0);
        check("midrst ready", 32'(req_ready), 0);
        check("midrst sys_resetn", 32'(sys_resetn), 0);
`ifdef PLL_PHASE_LOSSCNT_EN
        check("midrst loss_cnt", 32'(loss_cnt), 0);
`endif
        doneCnt  = 0;
        abortCnt = 0;
        for (int j = 0; j < 4; j++) begin
            if (done) doneCnt++;
            if (abort) abortCnt++;
            tick();
        end
        check("midrst done count", 32'(doneCnt), 0);
        check("midrst abort count", 32'(abortCnt), 0);
        resetn = 1'b1;
        waitReady(40, k);
        check("midrst requalify edge", 32'(k), 18);

`ifdef PLL_PHASE_LOSSCNT_EN
        // 300 lock-loss events: counter saturates at 255.
        for (int i = 0; i < 300; i++) begin
            locked = 1'b0;
            for (int j = 0; j < 3; j++) tick();
            locked = 1'b1;
            for (int j = 0; j < 19; j++) tick();
            if (i == 9) check("loss_cnt after 10", 32'(loss_cnt), 10);
        end
        check("loss_cnt saturated", 32'(loss_cnt), 255);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
